mems_mics_sample_buffer: RTL and testbench

Parametrised ping-pong sample buffer between the MEMS microphone decimation chain and the HPS/Nios Avalon-MM bus. It stores complete multi-channel frames into one of two on-chip RAM banks while the host reads the other. Banks swap only when the host has released the previous bank. Overflow and channel-misalignment events are counted, and an interrupt is raised when a full bank is ready.

---
 rtl/mems_mics_pkg.sv | 28 ++
 rtl/mems_mics_sdp_ram.sv | 24 ++
 rtl/mems_mics_sample_buffer.sv | 183 ++++++++++++++++++
 tb/tb_mems_mics_sample_buffer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mems_mics_pkg.sv
// Shared constants for the MEMS microphone ping-pong sample buffer:
// CSR map, STATUS/CONTROL bit positions, writer states and counter helpers.
package mems_mics_pkg;

  localparam int CNT_W = 16;

  localparam logic [1:0] CSR_STATUS   = 2'd0;
  localparam logic [1:0] CSR_CONTROL  = 2'd1;
  localparam logic [1:0] CSR_OVF      = 2'd2;
  localparam logic [1:0] CSR_SYNC_ERR = 2'd3;

  localparam int ST_BANK_READY = 0;
  localparam int ST_READY_BANK = 1;
  localparam int ST_ENABLE     = 2;
  localparam int ST_FILL       = 3;

  localparam int CT_ENABLE  = 0;
  localparam int CT_RELEASE = 1;
  localparam int CT_IRQ_EN  = 2;

  typedef enum logic {SYNC = 1'b0, FILL = 1'b1} wr_state_e;

  // Event counters stick at all-ones rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mems_mics_sdp_ram.sv
// Simple dual-port sample RAM: one write port, one read port with registered
// address and registered data (two-cycle read), written to infer block RAM.
module mems_mics_sdp_ram #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [(1 << ADDR_W)];
  logic [ADDR_W-1:0] rd_addr_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_addr_q <= rd_addr;
    rd_data   <= mem[rd_addr_q];
  end

endmodule

// File: rtl/mems_mics_sample_buffer.sv
// Ping-pong frame buffer between the mic decimation chain and Avalon-MM:
// writer FSM, bank hand-off, CSRs and the two-cycle read pipeline.
module mems_mics_sample_buffer
  import mems_mics_pkg::*;
#(
  parameter int DATA_W   = 24,
  parameter int CHANNELS = 8,
  parameter int DEPTH    = 256,
  parameter int CH_W     = $clog2(CHANNELS),
  parameter int FR_W     = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  input  logic [CH_W-1:0]      in_channel,
  input  logic [DATA_W-1:0]    in_data,
  input  logic [FR_W+CH_W:0]   avs_address,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [DATA_W-1:0]    avs_writedata,
  output logic [DATA_W-1:0]    avs_readdata,
  output logic                 avs_readdatavalid,
  output logic                 irq
);

  localparam int AW = FR_W + CH_W + 1;

  wr_state_e          state;
  logic [FR_W-1:0]    frame_idx;
  logic [CH_W-1:0]    ch_cnt, wr_ch;
  logic               wr_bank, ready_bank, bank_ready, enable, irq_en;
  logic [CNT_W-1:0]   ovf_cnt, sync_err_cnt;

  logic               wr_en, mismatch, frame_done, bank_done;
  logic               csr_sel, csr_wr, rel_req, bank_ready_eff;
  logic [1:0]         csr_addr;
  logic [DATA_W-1:0]  csr_rdata, ram_rdata;

  logic [1:0]              vld_pipe, csr_pipe;
  logic [1:0][DATA_W-1:0]  csr_data_pipe;
  logic                    unused_wdata;

  assign csr_sel  = avs_address[AW-1];
  assign csr_addr = avs_address[1:0];
  assign csr_wr   = avs_write & csr_sel;
  assign rel_req  = csr_wr && (csr_addr == CSR_CONTROL) && avs_writedata[CT_RELEASE];
  assign unused_wdata = ^avs_writedata[DATA_W-1:3];

  // Release is applied before a same-cycle bank completion sees bank_ready.
  assign bank_ready_eff = bank_ready & ~rel_req;

  always_comb begin
    wr_en    = 1'b0;
    wr_ch    = ch_cnt;
    mismatch = 1'b0;
    case (state)
      SYNC: if (in_valid && enable && in_channel == '0) begin
        wr_en = 1'b1;
        wr_ch = '0;
      end
      FILL: if (in_valid && enable) begin
        if (in_channel == ch_cnt) wr_en    = 1'b1;
        else                      mismatch = 1'b1;
      end
      default: ;
    endcase
  end

  assign frame_done = wr_en && (&wr_ch);
  assign bank_done  = frame_done && (&frame_idx);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= SYNC;
      frame_idx <= '0;
      ch_cnt    <= '0;
    end else begin
      case (state)
        SYNC: if (wr_en) begin
          state  <= FILL;
          ch_cnt <= CH_W'(1);
        end
        FILL: begin
          if (!enable) begin
            state     <= SYNC;
            frame_idx <= '0;
            ch_cnt    <= '0;
          end else if (mismatch) begin
            // frame_idx is kept so the partial frame gets rewritten.
            state  <= SYNC;
            ch_cnt <= '0;
          end else if (frame_done) begin
            ch_cnt    <= '0;
            frame_idx <= frame_idx + 1'b1;
          end else if (wr_en) begin
            ch_cnt <= ch_cnt + 1'b1;
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bank_ready   <= 1'b0;
      ready_bank   <= 1'b0;
      wr_bank      <= 1'b0;
      enable       <= 1'b0;
      irq_en       <= 1'b0;
      ovf_cnt      <= '0;
      sync_err_cnt <= '0;
    end else begin
      if (bank_done && !bank_ready_eff) begin
        bank_ready <= 1'b1;
        ready_bank <= wr_bank;
        wr_bank    <= ~wr_bank;
      end else begin
        bank_ready <= bank_ready_eff;
      end

      if (csr_wr && csr_addr == CSR_CONTROL) begin
        enable <= avs_writedata[CT_ENABLE];
        irq_en <= avs_writedata[CT_IRQ_EN];
      end

      if (csr_wr && csr_addr == CSR_OVF)   ovf_cnt <= '0;
      else if (bank_done && bank_ready_eff) ovf_cnt <= sat_inc(ovf_cnt);

      if (csr_wr && csr_addr == CSR_SYNC_ERR) sync_err_cnt <= '0;
      else if (mismatch)                      sync_err_cnt <= sat_inc(sync_err_cnt);
    end
  end

  assign irq = bank_ready & irq_en;

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_STATUS: begin
        csr_rdata[ST_BANK_READY] = bank_ready;
        csr_rdata[ST_READY_BANK] = ready_bank;
        csr_rdata[ST_ENABLE]     = enable;
        csr_rdata[ST_FILL]       = (state == FILL);
      end
      CSR_CONTROL: begin
        csr_rdata[CT_ENABLE] = enable;
        csr_rdata[CT_IRQ_EN] = irq_en;
      end
      CSR_OVF:  csr_rdata[CNT_W-1:0] = ovf_cnt;
      default:  csr_rdata[CNT_W-1:0] = sync_err_cnt;
    endcase
  end

  mems_mics_sdp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr ({wr_bank, frame_idx, wr_ch}),
    .wr_data (in_data),
    .rd_addr ({ready_bank, avs_address[FR_W+CH_W-1:0]}),
    .rd_data (ram_rdata)
  );

  // CSR data rides alongside the RAM's two register stages.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe      <= '0;
      csr_pipe      <= '0;
      csr_data_pipe <= '0;
    end else begin
      vld_pipe      <= {vld_pipe[0], avs_read};
      csr_pipe      <= {csr_pipe[0], csr_sel};
      csr_data_pipe <= {csr_data_pipe[0], csr_rdata};
    end
  end

  assign avs_readdatavalid = vld_pipe[1];
  assign avs_readdata = vld_pipe[1] ? (csr_pipe[1] ? csr_data_pipe[1] : ram_rdata) : '0;

endmodule

// File: tb/tb_mems_mics_sample_buffer.sv
// Directed bench for the ping-pong sample buffer (4 channels x 4 frames)
// against a transaction-level model of banks, CSRs and read latency.
module tb_mems_mics_sample_buffer;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_channel = '0;
  logic [23:0] in_data = '0;
  logic [4:0]  avs_address = '0;
  logic        avs_read = 1'b0, avs_write = 1'b0;
  logic [23:0] avs_writedata = '0;
  logic [23:0] avs_readdata;
  logic        avs_readdatavalid, irq;

  mems_mics_sample_buffer #(.DATA_W(24), .CHANNELS(4), .DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_channel(in_channel),
    .in_data(in_data), .avs_address(avs_address), .avs_read(avs_read),
    .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid), .irq(irq)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0, cyc = 0;

  bit m_en, m_ie, m_br, m_rb, m_wb, m_fill;
  int m_fr, m_ch, m_ovf, m_se;
  int m_mem [32];
  bit rd_due [int];
  int rd_exp [int];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int m_csr(input logic [1:0] a);
    case (a)
      2'd0:    return int'({28'd0, m_fill, m_en, m_rb, m_br});
      2'd1:    return int'({29'd0, m_ie, 1'b0, m_en});
      2'd2:    return m_ovf;
      default: return m_se;
    endcase
  endfunction

  task automatic m_reset();
    {m_en, m_ie, m_br, m_rb, m_wb, m_fill} = '0;
    m_fr = 0; m_ch = 0; m_ovf = 0; m_se = 0;
    rd_due.delete();
    rd_exp.delete();
  endtask

  task automatic m_write(input int ch, input int d);
    m_mem[m_wb*16 + m_fr*4 + ch] = d;
    if (ch == 3) begin
      m_ch = 0;
      if (m_fr == 3) begin
        if (!m_br) begin m_br = 1; m_rb = m_wb; m_wb = !m_wb; end
        else if (m_ovf < 16'hFFFF) m_ovf++;
      end
      m_fr = (m_fr + 1) % 4;
    end else m_ch = ch + 1;
  endtask

  // One clock: capture read expectation at issue, then apply the edge to the model.
  task automatic tick();
    bit w;
    logic [1:0]  wa;
    logic [23:0] wd;
    if (reset_n && avs_read) begin
      rd_due[cyc+2] = 1'b1;
      rd_exp[cyc+2] = avs_address[4] ? m_csr(avs_address[1:0])
                                     : m_mem[m_rb*16 + int'(avs_address[3:0])];
    end
    w  = reset_n && avs_write && avs_address[4];
    wa = avs_address[1:0];
    wd = avs_writedata;
    @(posedge clk);
    if (reset_n) begin
      if (w && wa == 2'd1 && wd[1]) m_br = 0;
      if (in_valid && m_en) begin
        if (!m_fill) begin
          if (in_channel == 0) begin m_fill = 1; m_write(0, int'(in_data)); end
        end else if (int'(in_channel) == m_ch) m_write(m_ch, int'(in_data));
        else begin
          m_fill = 0; m_ch = 0;
          if (m_se < 16'hFFFF) m_se++;
        end
      end else if (m_fill && !m_en) begin
        m_fill = 0; m_fr = 0; m_ch = 0;
      end
      if (w) case (wa)
        2'd1: begin m_en = wd[0]; m_ie = wd[2]; end
        2'd2: m_ovf = 0;
        2'd3: m_se = 0;
        default: ;
      endcase
    end
    cyc++;
    #1;
    in_valid = 1'b0; avs_read = 1'b0; avs_write = 1'b0;
  endtask

  task automatic smp(input int ch, input int d);
    in_valid = 1'b1; in_channel = ch[1:0]; in_data = d[23:0]; tick();
  endtask
  task automatic wr(input int a, input int d);
    avs_write = 1'b1; avs_address = a[4:0]; avs_writedata = d[23:0]; tick();
  endtask
  task automatic rd(input int a);
    avs_read = 1'b1; avs_address = a[4:0]; tick();
  endtask
  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  always @(negedge clk) begin
    chk("readdatavalid", avs_readdatavalid, rd_due.exists(cyc));
    chk("irq", irq, m_br & m_ie);
    if (rd_due.exists(cyc)) chk("readdata", avs_readdata, rd_exp[cyc]);
  end

  initial begin
    m_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = 0;
    idle(3);
    reset_n = 1'b1;
    rd(16); idle(2);
    chk("pin_status_reset", m_csr(0), 0);

    // Fill bank 0
    wr(17, 5); rd(17);
    for (int n = 0; n < 16; n++) smp(n % 4, 'h100 + n);
    chk("pin_fill_ready", {m_br, m_rb, m_wb}, 3'b101);
    chk("pin_fill_word5", m_mem[5], 'h105);
    chk("fill_irq", irq, 1);
    rd(5); rd(16); idle(2);
    chk("pin_fill_status", m_csr(0), 13);

    // Overflow: next bank completes with bank 0 still unreleased
    for (int n = 0; n < 16; n++) smp(n % 4, 'h200 + n);
    chk("pin_ovf_cnt", m_ovf, 1);
    chk("pin_ovf_wbank", m_wb, 1);
    chk("pin_ovf_bank0", m_mem[5], 'h105);
    rd(18); rd(5); idle(2);

    // Release on the same cycle as the last sample of bank 1
    wr(18, 0);
    for (int n = 0; n < 15; n++) smp(n % 4, 'h300 + n);
    in_valid = 1'b1; in_channel = 2'd3; in_data = 24'h30F;
    avs_write = 1'b1; avs_address = 5'd17; avs_writedata = 24'd7;
    tick();
    rd(5); rd(16); rd(18); idle(2);
    chk("pin_simrel", {m_br, m_rb, m_wb}, 3'b110);
    chk("pin_simrel_ovf", m_ovf, 0);
    chk("pin_simrel_word", m_mem[21], 'h30F - 10);

    // Release, redundant release, then misalignment 0,1,3
    wr(17, 7); wr(17, 7);
    smp(0, 'h400); smp(1, 'h401); smp(3, 'h403);
    rd(16); rd(19); idle(2);
    chk("pin_misalign_status", m_csr(0), 6);
    chk("pin_misalign_cnt", m_se, 1);
    for (int n = 0; n < 16; n++) smp(n % 4, 'h410 + n);
    chk("pin_resume_frame0", m_mem[0], 'h410);
    rd(0); rd(4); idle(2);

    // Back-to-back reads, then a same-cycle CSR write and read
    rd(16); rd(0); rd(18); rd(3); idle(1);
    avs_read = 1'b1; avs_write = 1'b1; avs_address = 5'd19; avs_writedata = '0;
    tick();
    rd(19); idle(2);
    chk("pin_pipe_status", m_csr(0), 13);

    // Clearing enable drops the writer back to SYNC
    wr(17, 4); rd(16); rd(16); wr(17, 5); idle(2);
    chk("pin_disabled", m_fill, 0);

    // Asynchronous reset mid-frame with a read in flight
    for (int n = 0; n < 6; n++) smp(n % 4, 'h500 + n);
    chk("irq_before_reset", irq, 1);
    avs_read = 1'b1; avs_address = 5'd16; tick();
    #2 reset_n = 1'b0;
    m_reset();
    #1;
    chk("valid_in_reset", avs_readdatavalid, 0);
    chk("irq_in_reset", irq, 0);
    idle(3);
    reset_n = 1'b1;
    rd(16); rd(17); rd(18); rd(19); idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
